pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 14 +
 rtl/adder_slice.sv | 27 ++
 rtl/pipelined_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_adder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation-mode encoding and the
// WIDTH/STAGES legality rule used at elaboration.
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_mode_e;

   function automatic bit params_ok(input int width, input int stages);
      return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry slice. Also exposes the carry into its MSB
// so the most significant slice can derive signed overflow.
module adder_slice #(
   parameter int SW = 8
) (
   input  logic [SW-1:0] i_a,
   input  logic [SW-1:0] i_b,
   input  logic          i_c,
   output logic [SW-1:0] o_s,
   output logic          o_c,
   output logic          o_msb_c
);

   always_comb begin
      logic c;
      c       = i_c;
      o_s     = '0;
      o_msb_c = i_c;
      for (int i = 0; i < SW; i++) begin
         o_msb_c = c;
         o_s[i]  = i_a[i] ^ i_b[i] ^ c;
         c       = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
      end
      o_c = c;
   end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: the WIDTH-bit chain is cut into STAGES
// equal slices, one per register stage, with a valid/ready handshake on each side.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             pipelined_adder_clk,
   input  logic             pipelined_adder_rst,
   input  logic             pipelined_adder_in_valid,
   output logic             pipelined_adder_in_ready,
   input  logic [WIDTH-1:0] pipelined_adder_a,
   input  logic [WIDTH-1:0] pipelined_adder_b,
   input  logic             pipelined_adder_carry_in,
   input  logic             pipelined_adder_sub,
   output logic             pipelined_adder_out_valid,
   input  logic             pipelined_adder_out_ready,
   output logic [WIDTH-1:0] pipelined_adder_sum,
   output logic             pipelined_adder_carry_out,
   output logic             pipelined_adder_overflow
);

   localparam int SW = (STAGES >= 1) ? (WIDTH / STAGES) : 1;
   localparam logic [WIDTH-1:0] ONES = '1;

   if (!params_ok(WIDTH, STAGES)) begin : g_param_check
      $error("pipelined_adder: WIDTH=%0d cannot be split into STAGES=%0d equal slices", WIDTH, STAGES);
   end

   logic             w_en;
   logic [WIDTH-1:0] w_b_ent;
   logic             w_c_ent;
   logic             w_ovf;

   logic             w_vld     [STAGES];
   logic [WIDTH-1:0] w_a       [STAGES];
   logic [WIDTH-1:0] w_b       [STAGES];
   logic [WIDTH-1:0] w_res     [STAGES];
   logic             w_ci      [STAGES];
   logic [SW-1:0]    w_s       [STAGES];
   logic             w_co      [STAGES];
   logic             w_mc      [STAGES];
   logic [WIDTH-1:0] w_res_nxt [STAGES];

   logic             r_vld [STAGES];
   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_res [STAGES];
   logic             r_cy  [STAGES];
   logic             r_ovf;

   // Whole pipe advances together; only a stalled, valid output freezes it.
   assign w_en    = !r_vld[STAGES-1] || pipelined_adder_out_ready;
   assign w_b_ent = (pipelined_adder_sub == OP_SUB) ? ~pipelined_adder_b : pipelined_adder_b;
   assign w_c_ent = (pipelined_adder_sub == OP_SUB) ? 1'b1 : pipelined_adder_carry_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam logic [WIDTH-1:0] SLICE_MASK = (ONES >> (WIDTH - SW)) << (k * SW);

      if (k == 0) begin : g_src
         assign w_vld[k] = pipelined_adder_in_valid;
         assign w_a[k]   = pipelined_adder_a;
         assign w_b[k]   = w_b_ent;
         assign w_ci[k]  = w_c_ent;
         assign w_res[k] = '0;
      end else begin : g_src
         assign w_vld[k] = r_vld[k-1];
         assign w_a[k]   = r_a[k-1];
         assign w_b[k]   = r_b[k-1];
         assign w_ci[k]  = r_cy[k-1];
         assign w_res[k] = r_res[k-1];
      end

      adder_slice #(
         .SW(SW)
      ) u_slice (
         .i_a     (w_a[k][k*SW +: SW]),
         .i_b     (w_b[k][k*SW +: SW]),
         .i_c     (w_ci[k]),
         .o_s     (w_s[k]),
         .o_c     (w_co[k]),
         .o_msb_c (w_mc[k])
      );

      assign w_res_nxt[k] = (w_res[k] & ~SLICE_MASK) | (WIDTH'(w_s[k]) << (k * SW));
   end

   // Carry into the sign bit differing from carry out of it is exactly the case of
   // same-sign operands producing an opposite-sign result.
   assign w_ovf = w_mc[STAGES-1] ^ w_co[STAGES-1];

   always_ff @(posedge pipelined_adder_clk or posedge pipelined_adder_rst) begin
      if (pipelined_adder_rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_res[k] <= '0;
            r_cy[k]  <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_en) begin
         for (int k = 0; k < STAGES; k++) begin
            r_vld[k] <= w_vld[k];
            r_a[k]   <= w_a[k];
            r_b[k]   <= w_b[k];
            r_res[k] <= w_res_nxt[k];
            r_cy[k]  <= w_co[k];
         end
         r_ovf <= w_ovf;
      end
   end

   assign pipelined_adder_in_ready  = w_en;
   assign pipelined_adder_out_valid = r_vld[STAGES-1];
   assign pipelined_adder_sum       = r_res[STAGES-1];
   assign pipelined_adder_carry_out = r_cy[STAGES-1];
   assign pipelined_adder_overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: an 8-bit 4-stage instance for handshake scenarios and
// 1-stage / 8-stage instances swept side by side against an arithmetic model.
module tb_pipelined_adder;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic         m_in_valid, m_in_ready, m_sub, m_cin, m_out_valid, m_out_ready, m_co, m_ovf;
   logic [W-1:0] m_a, m_b, m_sum;

   logic         s_valid, s_sub, s_cin, s_out_ready;
   logic [W-1:0] s_a, s_b;
   logic         s1_in_ready, s1_out_valid, s1_co, s1_ovf;
   logic [W-1:0] s1_sum;
   logic         s8_in_ready, s8_out_valid, s8_co, s8_ovf;
   logic [W-1:0] s8_sum;

   pipelined_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
      .pipelined_adder_clk       (clk),
      .pipelined_adder_rst       (rst),
      .pipelined_adder_in_valid  (m_in_valid),
      .pipelined_adder_in_ready  (m_in_ready),
      .pipelined_adder_a         (m_a),
      .pipelined_adder_b         (m_b),
      .pipelined_adder_carry_in  (m_cin),
      .pipelined_adder_sub       (m_sub),
      .pipelined_adder_out_valid (m_out_valid),
      .pipelined_adder_out_ready (m_out_ready),
      .pipelined_adder_sum       (m_sum),
      .pipelined_adder_carry_out (m_co),
      .pipelined_adder_overflow  (m_ovf)
   );

   pipelined_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
      .pipelined_adder_clk       (clk),
      .pipelined_adder_rst       (rst),
      .pipelined_adder_in_valid  (s_valid),
      .pipelined_adder_in_ready  (s1_in_ready),
      .pipelined_adder_a         (s_a),
      .pipelined_adder_b         (s_b),
      .pipelined_adder_carry_in  (s_cin),
      .pipelined_adder_sub       (s_sub),
      .pipelined_adder_out_valid (s1_out_valid),
      .pipelined_adder_out_ready (s_out_ready),
      .pipelined_adder_sum       (s1_sum),
      .pipelined_adder_carry_out (s1_co),
      .pipelined_adder_overflow  (s1_ovf)
   );

   pipelined_adder #(.WIDTH(W), .STAGES(8)) u_dut8 (
      .pipelined_adder_clk       (clk),
      .pipelined_adder_rst       (rst),
      .pipelined_adder_in_valid  (s_valid),
      .pipelined_adder_in_ready  (s8_in_ready),
      .pipelined_adder_a         (s_a),
      .pipelined_adder_b         (s_b),
      .pipelined_adder_carry_in  (s_cin),
      .pipelined_adder_sub       (s_sub),
      .pipelined_adder_out_valid (s8_out_valid),
      .pipelined_adder_out_ready (s_out_ready),
      .pipelined_adder_sum       (s8_sum),
      .pipelined_adder_carry_out (s8_co),
      .pipelined_adder_overflow  (s8_ovf)
   );

   // Reference: plain integer arithmetic, returns {carry_out, overflow, sum}.
   function automatic logic [9:0] model_op(input logic [7:0] a, input logic [7:0] b,
                                           input logic sub, input logic cin);
      int ua, ub, full, sa, sb, sres;
      logic co, ov;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      if (sub) begin
         full = ua - ub;
         co   = (ua >= ub);
         sres = sa - sb;
      end else begin
         full = ua + ub + int'(cin);
         co   = (full > 255);
         sres = sa + sb + int'(cin);
      end
      ov = (sres > 127) || (sres < -128);
      return {co, ov, full[7:0]};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      m_in_valid = 1'b0; m_a = '0; m_b = '0; m_sub = 1'b0; m_cin = 1'b0; m_out_ready = 1'b1;
      s_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0; s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", m_out_valid); end
      n_checks++; if (m_sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", m_sum); end
      n_checks++; if (m_co !== 1'b0) begin n_fail++; $display("FAIL reset_carry_out: got %b want 0", m_co); end
      n_checks++; if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", m_ovf); end
      n_checks++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", m_in_ready); end
      n_checks++; if ({s1_out_valid, s8_out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_sweep_valid: got %b%b want 00", s1_out_valid, s8_out_valid); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b want 0", m_out_valid); end
   endtask

   task automatic test_directed();
      logic [7:0] ta [5], tb [5], esum [5];
      logic       tsub [5], tcin [5], eco [5], eov [5];
      int edges;
      ta   = '{8'hFF, 8'h7F, 8'h10, 8'h05, 8'h80};
      tb   = '{8'h01, 8'h01, 8'h20, 8'h07, 8'h01};
      tsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tcin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      esum = '{8'h00, 8'h80, 8'h31, 8'hFE, 8'h7F};
      eco  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      eov  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      m_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         m_a = ta[i]; m_b = tb[i]; m_sub = tsub[i]; m_cin = tcin[i]; m_in_valid = 1'b1;
         @(posedge clk);
         #1;
         m_in_valid = 1'b0;
         edges = 1;
         while (m_out_valid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
         end
         n_checks++; if (edges != 4) begin n_fail++; $display("FAIL directed%0d_latency: got %0d edges want 4", i, edges); end
         n_checks++; if (m_sum !== esum[i]) begin n_fail++; $display("FAIL directed%0d_sum: got %h want %h", i, m_sum, esum[i]); end
         n_checks++; if (m_co !== eco[i]) begin n_fail++; $display("FAIL directed%0d_carry_out: got %b want %b", i, m_co, eco[i]); end
         n_checks++; if (m_ovf !== eov[i]) begin n_fail++; $display("FAIL directed%0d_overflow: got %b want %b", i, m_ovf, eov[i]); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] q [$];
      logic [9:0] got, exp;
      int sent = 0, rcvd = 0, first = -1, last = -1, cyc = 0;
      m_out_ready = 1'b1;
      while ((sent < 16 || q.size() > 0) && cyc < 60) begin
         if (sent < 16) begin
            m_a = 8'($urandom); m_b = 8'($urandom); m_sub = 1'($urandom); m_cin = 1'($urandom);
            m_in_valid = 1'b1;
         end else begin
            m_in_valid = 1'b0;
         end
         @(negedge clk);
         if (m_out_valid) begin
            got = {m_co, m_ovf, m_sum};
            exp = (q.size() > 0) ? q.pop_front() : 10'h3FF;
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_result%0d: got %h want %h", rcvd, got, exp); end
            rcvd++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (m_in_valid && m_in_ready) begin
            q.push_back(model_op(m_a, m_b, m_sub, m_cin));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      m_in_valid = 1'b0;
      n_checks++; if (rcvd != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", rcvd); end
      n_checks++; if (last - first != 15) begin n_fail++; $display("FAIL b2b_throughput: span %0d cycles want 15", last - first); end
   endtask

   task automatic test_stall();
      logic [9:0]  q [$];
      logic [9:0]  got, exp;
      logic [10:0] held;
      logic        hold = 1'b0;
      int sent = 0, rcvd = 0, cyc = 0;
      while ((sent < 24 || q.size() > 0) && cyc < 80) begin
         m_out_ready = !(cyc >= 8 && cyc <= 12);
         if (sent < 24) begin
            if (!hold) begin
               m_a = 8'($urandom); m_b = 8'($urandom); m_sub = 1'($urandom); m_cin = 1'($urandom);
            end
            m_in_valid = 1'b1;
         end else begin
            m_in_valid = 1'b0;
         end
         @(negedge clk);
         if (cyc >= 8 && cyc <= 12) begin
            n_checks++; if ({m_out_valid, m_in_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_ready_c%0d: got valid/ready %b%b want 10", cyc, m_out_valid, m_in_ready); end
            if (cyc == 8) held = {m_out_valid, m_co, m_ovf, m_sum};
            else begin
               n_checks++; if ({m_out_valid, m_co, m_ovf, m_sum} !== held) begin n_fail++; $display("FAIL stall_hold_c%0d: got %h want %h", cyc, {m_out_valid, m_co, m_ovf, m_sum}, held); end
            end
         end
         if (m_out_valid && m_out_ready) begin
            got = {m_co, m_ovf, m_sum};
            exp = (q.size() > 0) ? q.pop_front() : 10'h3FF;
            n_checks++; if (got !== exp) begin n_fail++; $display("FAIL stall_result%0d: got %h want %h", rcvd, got, exp); end
            rcvd++;
         end
         hold = m_in_valid && !m_in_ready;
         if (m_in_valid && m_in_ready) begin
            q.push_back(model_op(m_a, m_b, m_sub, m_cin));
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      m_in_valid = 1'b0;
      m_out_ready = 1'b1;
      n_checks++; if (rcvd != 24 || sent != 24) begin n_fail++; $display("FAIL stall_count: got %0d out of %0d sent, want 24/24", rcvd, sent); end
   endtask

   task automatic test_reset_midflight();
      logic [9:0] exp;
      int edges;
      logic seen = 1'b0;
      m_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_a = 8'($urandom); m_b = 8'($urandom); m_sub = 1'($urandom); m_cin = 1'($urandom);
         m_in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      m_in_valid = 1'b0;
      n_checks++; if (m_out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_precondition: out_valid %b want 1", m_out_valid); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", m_out_valid); end
      n_checks++; if (m_sum !== 8'h00) begin n_fail++; $display("FAIL midrst_sum: got %h want 00", m_sum); end
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (m_out_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_leftover: got out_valid after reset want none"); end
      m_a = 8'($urandom); m_b = 8'($urandom); m_sub = 1'($urandom); m_cin = 1'($urandom);
      exp = model_op(m_a, m_b, m_sub, m_cin);
      m_in_valid = 1'b1;
      @(posedge clk);
      #1;
      m_in_valid = 1'b0;
      edges = 1;
      while (m_out_valid !== 1'b1 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      n_checks++; if (edges != 4) begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d edges want 4", edges); end
      n_checks++; if ({m_co, m_ovf, m_sum} !== exp) begin n_fail++; $display("FAIL midrst_fresh_result: got %h want %h", {m_co, m_ovf, m_sum}, exp); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_sweep();
      localparam int TOTAL = 256 * 32 * 2;
      logic [7:0] bl [32];
      logic [7:0] fx [8];
      logic [9:0] q1 [$], q8 [$];
      int         e1 [$], e8 [$];
      logic [9:0] exp;
      int ee, edges = 0, idx = 0;
      fx = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
      for (int i = 0; i < 32; i++) bl[i] = (i < 8) ? fx[i] : 8'($urandom);
      s_out_ready = 1'b1;
      while ((idx < TOTAL || q1.size() > 0 || q8.size() > 0) && edges < TOTAL + 50) begin
         if (idx < TOTAL) begin
            s_a = 8'(idx >> 6); s_b = bl[(idx >> 1) & 31]; s_sub = 1'(idx & 1); s_cin = 1'($urandom);
            s_valid = 1'b1;
         end else begin
            s_valid = 1'b0;
         end
         @(negedge clk);
         if (s1_out_valid) begin
            exp = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
            ee  = (e1.size() > 0) ? e1.pop_front() : -100;
            n_checks++; if ({s1_co, s1_ovf, s1_sum} !== exp) begin n_fail++; $display("FAIL sweep1_result: got %h want %h", {s1_co, s1_ovf, s1_sum}, exp); end
            n_checks++; if (edges != ee) begin n_fail++; $display("FAIL sweep1_latency: at edge %0d want edge %0d", edges, ee); end
         end
         if (s8_out_valid) begin
            exp = (q8.size() > 0) ? q8.pop_front() : 10'h3FF;
            ee  = (e8.size() > 0) ? e8.pop_front() : -100;
            n_checks++; if ({s8_co, s8_ovf, s8_sum} !== exp) begin n_fail++; $display("FAIL sweep8_result: got %h want %h", {s8_co, s8_ovf, s8_sum}, exp); end
            n_checks++; if (edges != ee + 7) begin n_fail++; $display("FAIL sweep8_latency: at edge %0d want edge %0d", edges, ee + 7); end
         end
         if (s_valid && s1_in_ready) begin q1.push_back(model_op(s_a, s_b, s_sub, s_cin)); e1.push_back(edges + 1); end
         if (s_valid && s8_in_ready) begin q8.push_back(model_op(s_a, s_b, s_sub, s_cin)); e8.push_back(edges + 1); end
         if (s_valid && s1_in_ready && s8_in_ready) idx++;
         @(posedge clk);
         #1;
         edges++;
      end
      s_valid = 1'b0;
      n_checks++; if (idx != TOTAL || q1.size() != 0 || q8.size() != 0) begin n_fail++; $display("FAIL sweep_drain: sent %0d of %0d, left %0d/%0d", idx, TOTAL, q1.size(), q8.size()); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
